mm_access: RTL
==============

// Module: mm_access
// PURPOSE
//  Memory-access stage directly downstream of step_ex. Consumes the EX result, memory address/type/size and rt value.
//  Drives a single-outstanding request/ack data bus: byte lanes, LWL/LWR/SWL/SWR merging, sign/zero extension.
//  Produces registered write-back fields. Stalls upstream while a bus access is pending.
// PARAMETERS
//  TIMEOUT  255  max cycles to wait for bus_ack before aborting the access (1..255)
// PORTS
//  clk              in   1   clock
//  rst              in   1   asynchronous, active-high reset
//  in_valid         in   1   EX outputs below are valid this cycle
//  mem_access_type  in   2   0=R2R, 1=M2R (load), 2=R2M (store); 3 treated as R2R
//  mem_access_size  in   3   0=byte 1=half 2=word 3=left(LWL/SWL) 4=right(LWR/SWR); 5-7 treated as word
//  mem_sign_ext     in   1   sign-extend byte/half loads (LB/LH)
//  mem_access_addr  in   32  byte address
//  val_output       in   32  R2R: result; M2R: old rt (merge base); R2M: store data
//  bypass_reg_addr  in   5   destination register, 0 = no write
//  stall_o          out  1   hold EX/upstream this cycle
//  addr_err         out  1   1-cycle pulse: misaligned half/word access, no bus cycle issued
//  bus_err          out  1   1-cycle pulse: access aborted by timeout
//  bus_addr         out  32  word address {addr[31:2],2'b00}
//  bus_be           out  4   byte enables, bit i = byte lane i (little-endian)
//  bus_wdata        out  32  lane-aligned store data
//  bus_rd / bus_wr  out  1   request strobes, held until ack or timeout
//  bus_rdata        in   32  read data, valid with bus_ack
//  bus_ack          in   1   access complete this cycle
//  wb_we            out  1   write-back enable (registered)
//  wb_reg_addr      out  5   write-back register (registered)
//  wb_data          out  32  write-back value (registered)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-access drops the request immediately.
//  FSM IDLE/ACCESS.
//  IDLE, in_valid, R2R: next edge wb_we=(bypass_reg_addr!=0), wb_reg_addr, wb_data=val_output; stall_o=0.
//  IDLE, in_valid, M2R/R2M:
//   - Alignment check: half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
//   - Misaligned: addr_err pulses next cycle, wb_we=0, no bus cycle, stay IDLE, stall_o=0.
//   - Otherwise: stall_o=1 combinationally; latch request; go ACCESS; counter=0.
//  IDLE, !in_valid: wb_we=0 next edge.
//  ACCESS:
//   - bus_rd (load) or bus_wr (store) is registered high; counter increments each cycle.
//   - stall_o=!bus_ack.
//   - On bus_ack: strobes drop next edge, state=IDLE, write-back registered (load: wb_we=(rd!=0); store: wb_we=0).
//   - counter==TIMEOUT-1 without ack: drop strobes, bus_err pulse, wb_we=0, IDLE, stall_o=0.
//   - Inputs are ignored in ACCESS; upstream holds them via stall_o.
//  Min load latency: accept at cycle N, ack at N+1, wb_* valid at N+2.
//  Lanes, o=addr[1:0], r=rt, m=bus_rdata:
//   - byte: be=1<<o, wdata={4{r[7:0]}}, load=ext(m[8o+7:8o]).
//   - half: be=3<<o, wdata={2{r[15:0]}}, load=ext(m[8o+15:8o]).
//   - word: be=4'hF, wdata=r, load=m.
//   - LWL: data=(m<<8(3-o)) | (r & ~(32'hFFFFFFFF<<8(3-o))).
//   - LWR: data=(m>>8o) | (r & ~(32'hFFFFFFFF>>8o)).
//   - SWL: be=(4'b0001<<(o+1))-1, wdata=r>>8(3-o).
//   - SWR: be=4'hF<<o, wdata=r<<8o.
//   - ext: sign- or zero-extension per mem_sign_ext; left/right ignore it.
//  bus_addr/bus_be/bus_wdata are stable for the whole of ACCESS and 0 in IDLE.
// TESTING
//  R2R: val_output=32'h1234, rd=5 -> next cycle wb_we=1, wb_reg_addr=5, wb_data=32'h1234, stall_o=0.
//  LB addr=0x..03, sign_ext=1, rdata=0x80FFFFFF, ack 3 cycles late -> stall 4 cycles, be=4'b1000, wb_data=0xFFFFFF80.
//  SWR addr o=2, r=0xAABBCCDD -> be=4'b1100, wdata=0xCCDD0000; LWL o=1, m=0x11223344, r=0xAABBCCDD -> wb_data=0x3344CCDD.
//  LH addr=0x...1 -> addr_err pulse, no bus_rd, wb_we=0, stall_o=0.
//  No ack for TIMEOUT cycles -> bus_err pulse, strobes drop, IDLE; next op proceeds normally.
//  rst asserted during ACCESS -> bus_rd=0 and all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/mm_access.sv
// mm_access: memory-access stage with single-outstanding req/ack bus, lane steering and write-back register
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid, mem_access_type/size, mem_sign_ext, mem_access_addr, val_output, bypass_reg_addr
//                                 EX-stage result and memory request
//   stall_o                       hold upstream this cycle
//   addr_err, bus_err             1-cycle error pulses (misaligned, timeout)
//   bus_addr/be/wdata/rd/wr       bus request, stable for the whole access
//   bus_rdata, bus_ack            bus response
//   wb_we, wb_reg_addr, wb_data   registered write-back fields
module mm_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  mem_access_type,
    input  logic [2:0]  mem_access_size,
    input  logic        mem_sign_ext,
    input  logic [31:0] mem_access_addr,
    input  logic [31:0] val_output,
    input  logic [4:0]  bypass_reg_addr,
    output logic        stall_o,
    output logic        addr_err,
    output logic        bus_err,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        bus_rd,
    output logic        bus_wr,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        wb_we,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_data
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t state, state_n;
    logic [7:0]  cnt;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        sext_q, load_q;
    logic [31:0] rt_q;
    logic [4:0]  rd_q;
    logic        is_mem, misal, accept, done, abort;
    logic [2:0]  sz;
    logic [1:0]  o;
    logic [4:0]  swl;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, sh, ld;
    always_comb begin
        is_mem  = in_valid && (mem_access_type == 2'd1 || mem_access_type == 2'd2);
        sz      = (mem_access_size > 3'd4) ? 3'd2 : mem_access_size;
        o       = mem_access_addr[1:0];
        misal   = (sz == 3'd1 && o[0]) || (sz == 3'd2 && o != 2'd0);
        accept  = state == IDLE && is_mem && !misal;
        done    = state == ACCESS && bus_ack;
        abort   = state == ACCESS && !bus_ack && cnt == 8'(TIMEOUT - 1);
        state_n = accept ? ACCESS : (done || abort) ? IDLE : state;
        stall_o = !rst && (accept || (state == ACCESS && !bus_ack && !abort));
        // widened so that o=3 shifts by 4 rather than wrapping to 0
        swl     = (5'd1 << ({1'b0, o} + 3'd1)) - 5'd1;
        be_n    = sz == 3'd0 ? 4'b0001 << o :
                  sz == 3'd1 ? 4'b0011 << o :
                  sz == 3'd3 ? swl[3:0] :
                  sz == 3'd4 ? 4'hF << o : 4'hF;
        wdata_n = mem_access_type == 2'd1 ? 32'h0 :
                  sz == 3'd0 ? {4{val_output[7:0]}} :
                  sz == 3'd1 ? {2{val_output[15:0]}} :
                  sz == 3'd3 ? val_output >> {~o, 3'b000} :
                  sz == 3'd4 ? val_output << {o, 3'b000} : val_output;
        sh      = bus_rdata >> {off_q, 3'b000};
        ld      = size_q == 3'd0 ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                  size_q == 3'd1 ? {{16{sext_q & sh[15]}}, sh[15:0]} :
                  size_q == 3'd3 ? (bus_rdata << {~off_q, 3'b000}) | (rt_q & ~(32'hFFFFFFFF << {~off_q, 3'b000})) :
                  size_q == 3'd4 ? sh | (rt_q & ~(32'hFFFFFFFF >> {off_q, 3'b000})) : bus_rdata;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            size_q      <= '0;
            off_q       <= '0;
            sext_q      <= 1'b0;
            load_q      <= 1'b0;
            rt_q        <= '0;
            rd_q        <= '0;
            addr_err    <= 1'b0;
            bus_err     <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            bus_rd      <= 1'b0;
            bus_wr      <= 1'b0;
            wb_we       <= 1'b0;
            wb_reg_addr <= '0;
            wb_data     <= '0;
        end else begin
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            wb_we    <= 1'b0;
            if (state == IDLE) begin
                if (in_valid && !is_mem) begin
                    wb_we       <= bypass_reg_addr != 5'd0;
                    wb_reg_addr <= bypass_reg_addr;
                    wb_data     <= val_output;
                end
                addr_err <= is_mem && misal;
                if (accept) begin
                    cnt       <= '0;
                    size_q    <= sz;
                    off_q     <= o;
                    sext_q    <= mem_sign_ext;
                    load_q    <= mem_access_type == 2'd1;
                    rt_q      <= val_output;
                    rd_q      <= bypass_reg_addr;
                    bus_addr  <= {mem_access_addr[31:2], 2'b00};
                    bus_be    <= be_n;
                    bus_wdata <= wdata_n;
                    bus_rd    <= mem_access_type == 2'd1;
                    bus_wr    <= mem_access_type == 2'd2;
                end
            end else begin
                cnt <= cnt + 8'd1;
                if (done || abort) begin
                    bus_addr  <= '0;
                    bus_be    <= '0;
                    bus_wdata <= '0;
                    bus_rd    <= 1'b0;
                    bus_wr    <= 1'b0;
                    bus_err   <= abort;
                end
                if (done && load_q) begin
                    wb_we       <= rd_q != 5'd0;
                    wb_reg_addr <= rd_q;
                    wb_data     <= ld;
                end
            end
        end
    end
endmodule
